// File: rtl/boxcar_defs.sv
// Shared definitions for the boxcar decimator: FSM encodings, default
// exponent limit and the accumulator / exponent width formulas.
package boxcar_defs;

  localparam logic [0:0] ST_START = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam int DEFAULT_MAX_LOG2 = 10;

  // Summing 2^MAX_LOG2 samples needs MAX_LOG2 extra bits, so the sum never overflows.
  function automatic int acc_width(int width, int max_log2);
    return width + max_log2;
  endfunction

  // Width needed to hold an exponent in the range 0..max_log2.
  function automatic int dec_width(int max_log2);
    return $clog2(max_log2 + 1);
  endfunction

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample-stream bundle between the ADC front end and the boxcar decimator.
// master drives samples and control; slave (the decimator) returns the
// decimated word and its strobe.
interface boxcar_decimator_if #(
  parameter int WIDTH  = 16,
  parameter int LOG2_W = 4
);
  logic                     en_i;
  logic                     clr_i;
  logic signed [WIDTH-1:0]  data_i;
  logic [LOG2_W-1:0]        log2_dec_i;
  logic signed [WIDTH-1:0]  data_o;
  logic                     valid_o;

  modport master (
    output en_i, clr_i, data_i, log2_dec_i,
    input  data_o, valid_o
  );

  modport slave (
    input  en_i, clr_i, data_i, log2_dec_i,
    output data_o, valid_o
  );
endinterface

// File: rtl/boxcar_round_shift.sv
// Divides a frame sum by 2^dec with an arithmetic shift.
// Build option BOXCAR_ROUND_EN: when defined, round half up; otherwise
// truncate toward negative infinity. A zero exponent passes the sum through.
module boxcar_round_shift
  import boxcar_defs::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = DEFAULT_MAX_LOG2
) (
  input  logic signed [acc_width(WIDTH, MAX_LOG2)-1:0] sum,
  input  logic [dec_width(MAX_LOG2)-1:0]               dec,
  output logic signed [WIDTH-1:0]                      result
);
  localparam int AW = acc_width(WIDTH, MAX_LOG2);

  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;

  // Optional half-LSB bias, then the divide; the mean always fits WIDTH bits.
  always_comb begin
    biased = sum;
`ifdef BOXCAR_ROUND_EN
    if (dec != '0) begin
      biased = sum + (AW'(1) << (dec - 1'b1));
    end
`endif
    shifted = biased >>> dec;
    result  = WIDTH'(shifted);
  end
endmodule

// File: rtl/boxcar_decimator.sv
// Boxcar decimator: averages 2^k signed samples per frame and emits one
// held output word with a single-cycle valid strobe. k is latched only at
// frame start and clamped to MAX_LOG2. Build option BOXCAR_ROUND_EN selects
// round-half-up instead of floor (see boxcar_round_shift).
module boxcar_decimator
  import boxcar_defs::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = DEFAULT_MAX_LOG2,
  parameter int LOG2_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  boxcar_decimator_if.slave  bus
);
  localparam int AW = acc_width(WIDTH, MAX_LOG2);
  localparam int DW = dec_width(MAX_LOG2);

  logic [0:0]              state;
  logic signed [AW-1:0]    acc;
  logic [MAX_LOG2-1:0]     cnt;
  logic [DW-1:0]           dec_q;
  logic signed [WIDTH-1:0] data_q;
  logic                    valid_q;

  logic [LOG2_W-1:0]       req_dec;
  logic [DW-1:0]           new_dec;
  logic [DW-1:0]           shift_dec;
  logic [MAX_LOG2:0]       frame_len;
  logic signed [AW-1:0]    sample_ext;
  logic signed [AW-1:0]    sum;
  logic                    closing;
  logic signed [WIDTH-1:0] mean;

  assign req_dec     = bus.log2_dec_i;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;

  // Clamp the requested exponent, form the running sum including this
  // sample and decide whether this sample closes the frame.
  always_comb begin
    if (32'(req_dec) > MAX_LOG2) begin
      new_dec = DW'(MAX_LOG2);
    end else begin
      new_dec = DW'(req_dec);
    end
    sample_ext = AW'(bus.data_i);
    frame_len  = (MAX_LOG2 + 1)'(1) << dec_q;
    if (state == ST_START) begin
      sum       = sample_ext;
      shift_dec = new_dec;
      closing   = (new_dec == '0);
    end else begin
      sum       = acc + sample_ext;
      shift_dec = dec_q;
      closing   = ({1'b0, cnt} == frame_len - 1'b1);
    end
  end

  boxcar_round_shift #(
    .WIDTH    (WIDTH),
    .MAX_LOG2 (MAX_LOG2)
  ) u_round_shift (
    .sum    (sum),
    .dec    (shift_dec),
    .result (mean)
  );

  // Frame FSM, accumulator and sample counter; clear beats enable, idle cycles hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_START;
      acc     <= '0;
      cnt     <= '0;
      dec_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clr_i) begin
        acc   <= '0;
        cnt   <= '0;
        state <= ST_START;
      end else if (bus.en_i) begin
        if (state == ST_START) begin
          dec_q <= new_dec;
        end
        if (closing) begin
          data_q  <= mean;
          valid_q <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
          state   <= ST_START;
        end else if (state == ST_START) begin
          acc   <= sample_ext;
          cnt   <= MAX_LOG2'(1);
          state <= ST_ACCUM;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
